// File: rtl/hazard_scheduler.sv
// hazard_scheduler: load-use stall and taken-branch squash sequencer for the
// 5-stage pipeline. Control outputs are combinational from State and the
// hazard/branch inputs; State, the stall/flush down-counter and the two
// saturating debug event counters are registered.
module hazard_scheduler #(
    parameter int REG_ADDR_W   = 5,
    parameter int PC_W         = 8,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs2,
    input  logic                  IF_ID_UsesRs2,
    input  logic [REG_ADDR_W-1:0] ID_EX_Rd,
    input  logic                  ID_EX_MemRead,
    input  logic                  EX_MEM_Branch,
    input  logic [PC_W-1:0]       EX_MEM_BranchTarget,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Bubble,
    output logic                  PC_Load,
    output logic [PC_W-1:0]       PC_LoadValue,
    output logic [1:0]            State,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    // The down-counter holds "extra cycles left after this one", so it never
    // needs to represent more than max(STALL_CYCLES, FLUSH_CYCLES) - 2.
    localparam int MAX_C = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int DC_W  = (MAX_C > 2) ? $clog2(MAX_C - 1) : 1;
    localparam logic [DC_W-1:0] STALL_INIT = DC_W'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);
    localparam logic [DC_W-1:0] FLUSH_INIT = DC_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    logic [1:0]       state_q, state_d;
    logic [DC_W-1:0]  dc_q, dc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hz;
    logic             stall_inc;
    logic             flush_inc;

    assign hz = ID_EX_MemRead && (ID_EX_Rd != '0) &&
                ((ID_EX_Rd == IF_ID_Rs1) || (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));

    // Next-state, event strobes and pipeline control outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        dc_d         = dc_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        PC_Load      = 1'b0;
        PC_LoadValue = '0;

        if (state_q == S_FLUSH) begin
            // Wrong-path cycles: branch and hazard inputs are not trusted.
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            if (dc_q == '0) state_d = S_RUN;
            else            dc_d    = dc_q - 1'b1;
        end else if (EX_MEM_Branch) begin
            // Taken branch wins over a pending stall or a new hazard.
            PC_Load      = 1'b1;
            PC_LoadValue = EX_MEM_BranchTarget;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = S_FLUSH;
                dc_d    = FLUSH_INIT;
            end else begin
                state_d = S_RUN;
            end
        end else if (state_q == S_STALL) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            stall_inc    = 1'b1;
            if (dc_q == '0) state_d = S_RUN;
            else            dc_d    = dc_q - 1'b1;
        end else if (hz) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            stall_inc    = 1'b1;
            if (STALL_CYCLES > 1) begin
                state_d = S_STALL;
                dc_d    = STALL_INIT;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            state_d = S_RUN;
        end

        // While reset is asserted the pipeline front end is held quiet.
        if (rst) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            PC_Load      = 1'b0;
            PC_LoadValue = '0;
        end
    end

    // Saturating event counters: stick at all-ones.
    always_comb begin
        stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from the
        // same pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_RUN;
            dc_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dc_q        <= dc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign State      = state_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Testbench for hazard_scheduler: two instances (default parameters, and
// STALL_CYCLES=3/CNT_W=4) share one stimulus stream; each is checked every
// cycle against a cycle-count reference model, plus directed spot checks.
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       uses_rs2, mem_read, br;
    logic [7:0] tgt;

    logic        a_pcw, a_ifw, a_fl, a_bub, a_pcl;
    logic [7:0]  a_pcv;
    logic [1:0]  a_st;
    logic [15:0] a_sc, a_fc;

    logic        b_pcw, b_ifw, b_fl, b_bub, b_pcl;
    logic [7:0]  b_pcv;
    logic [1:0]  b_st;
    logic [3:0]  b_sc, b_fc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int mode;   // 0 run, 1 stall, 2 flush
        int left;   // further cycles still to spend in stall/flush
        int sc;
        int fc;
    } mdl_t;

    mdl_t ma, mb;

    always #5 clk = ~clk;

    hazard_scheduler dut_a (
        .clk(clk), .rst(rst),
        .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_UsesRs2(uses_rs2),
        .ID_EX_Rd(rd), .ID_EX_MemRead(mem_read),
        .EX_MEM_Branch(br), .EX_MEM_BranchTarget(tgt),
        .PC_Write(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_fl),
        .ID_EX_Bubble(a_bub), .PC_Load(a_pcl), .PC_LoadValue(a_pcv),
        .State(a_st), .StallCount(a_sc), .FlushCount(a_fc)
    );

    hazard_scheduler #(.STALL_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_UsesRs2(uses_rs2),
        .ID_EX_Rd(rd), .ID_EX_MemRead(mem_read),
        .EX_MEM_Branch(br), .EX_MEM_BranchTarget(tgt),
        .PC_Write(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_fl),
        .ID_EX_Bubble(b_bub), .PC_Load(b_pcl), .PC_LoadValue(b_pcv),
        .State(b_st), .StallCount(b_sc), .FlushCount(b_fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hazard();
        return mem_read && (rd != 0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

    // Expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, PC_Load, PC_LoadValue}.
    function automatic logic [12:0] exp_ctrl(input int mode);
        if (rst)            return {5'b00110, 8'h00};
        else if (mode == 2) return {5'b11110, 8'h00};
        else if (br)        return {5'b11111, tgt};
        else if (mode == 1 || hazard()) return {5'b00010, 8'h00};
        else                return {5'b11000, 8'h00};
    endfunction

    function automatic int sat_inc(input int v, input int cmax);
        return (v < cmax) ? v + 1 : v;
    endfunction

    // Advance a model by one clock edge using the inputs currently applied.
    task automatic advance(inout mdl_t m, input int stall_len, input int flush_len, input int cmax);
        if (rst) begin
            m = '{0, 0, 0, 0};
        end else if (m.mode == 2) begin
            m.left--;
            if (m.left <= 0) m.mode = 0;
        end else if (br) begin
            m.fc   = sat_inc(m.fc, cmax);
            m.left = flush_len - 1;
            m.mode = (m.left > 0) ? 2 : 0;
        end else if (m.mode == 1) begin
            m.sc = sat_inc(m.sc, cmax);
            m.left--;
            if (m.left <= 0) m.mode = 0;
        end else if (hazard()) begin
            m.sc   = sat_inc(m.sc, cmax);
            m.left = stall_len - 1;
            m.mode = (m.left > 0) ? 1 : 0;
        end
    endtask

    task automatic check_dut(input string tag, input mdl_t m, input logic [12:0] ctrl,
                             input logic [1:0] st, input int sc, input int fc);
        check({tag, ".ctrl"}, 32'(ctrl), 32'(exp_ctrl(m.mode)));
        check({tag, ".state"}, 32'(st), 32'(m.mode));
        check({tag, ".stall_cnt"}, 32'(sc), 32'(m.sc));
        check({tag, ".flush_cnt"}, 32'(fc), 32'(m.fc));
    endtask

    // Apply one cycle of inputs, check both DUTs, then step the models.
    task automatic step(input logic r, input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                        input logic [4:0] d, input logic mr, input logic b, input logic [7:0] t);
        @(negedge clk);
        rst = r; rs1 = s1; rs2 = s2; uses_rs2 = u2; rd = d; mem_read = mr; br = b; tgt = t;
        #1;
        check_dut("A", ma, {a_pcw, a_ifw, a_fl, a_bub, a_pcl, a_pcv}, a_st, int'(a_sc), int'(a_fc));
        check_dut("B", mb, {b_pcw, b_ifw, b_fl, b_bub, b_pcl, b_pcv}, b_st, int'(b_sc), int'(b_fc));
        advance(ma, 1, 2, 65535);
        advance(mb, 3, 2, 15);
    endtask

    task automatic idle();
        step(1'b0, 5'd1, 5'd2, 1'b0, 5'd7, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic hz_cyc();
        step(1'b0, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic reset2();
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; uses_rs2 = 1'b0; rd = '0; mem_read = 1'b0; br = 1'b0; tgt = '0;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        @(posedge clk);

        // Reset behaviour.
        reset2();
        check("rst_pcw", 32'(a_pcw), 32'd0);
        check("rst_flush", 32'(a_fl), 32'd1);
        check("rst_counts", {a_sc, a_fc}, 32'd0);
        idle();
        check("run_pcw_ifw", {a_pcw, a_ifw}, 32'd3);

        // Single-cycle load-use stall.
        hz_cyc();
        check("hz_pcw_ifw_bub", {a_pcw, a_ifw, a_bub}, 32'b001);
        idle();
        check("hz_stall_cnt", 32'(a_sc), 32'd1);
        check("hz_state", 32'(a_st), 32'd0);

        // Rd=0 never stalls; Rs2 only matters when used.
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 8'd0);
        check("rd0_no_stall", 32'(a_pcw), 32'd1);
        step(1'b0, 5'd1, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 8'd0);
        check("rs2_unused", 32'(a_pcw), 32'd1);
        step(1'b0, 5'd1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 8'd0);
        check("rs2_used", 32'(a_pcw), 32'd0);

        // Taken branch: redirect, then one FLUSH cycle.
        step(1'b0, 5'd1, 5'd2, 1'b0, 5'd7, 1'b0, 1'b1, 8'd40);
        check("br_load", {a_pcl, a_fl, 8'(a_pcv)}, {22'd0, 2'b11, 8'd40});
        idle();
        check("br_flush_state", 32'(a_st), 32'd2);
        idle();
        check("br_back_run", 32'(a_st), 32'd0);
        check("br_flush_cnt", 32'(a_fc), 32'd1);

        // Branch beats hazard; branch during FLUSH ignored.
        reset2();
        step(1'b0, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 8'd9);
        check("br_hz_pcw", {a_pcw, a_pcl}, 32'b11);
        step(1'b0, 5'd1, 5'd2, 1'b0, 5'd7, 1'b0, 1'b1, 8'd77);
        check("flush_ignores_br", 32'(a_pcl), 32'd0);
        idle();
        check("br_hz_counts", {a_sc, a_fc}, {16'd0, 16'd1});

        // Three-cycle stall on instance B, aborted stall, reset mid-flush.
        reset2();
        hz_cyc();
        idle();
        check("b_stall2", {b_st, b_pcw}, 32'b010);
        idle();
        idle();
        check("b_stall_cnt3", {b_st, b_sc}, {26'd0, 2'd0, 4'd3});
        hz_cyc();
        step(1'b0, 5'd1, 5'd2, 1'b0, 5'd7, 1'b0, 1'b1, 8'd5);
        check("b_abort_load", 32'(b_pcl), 32'd1);
        check("b_abort_sc", 32'(b_sc), 32'd4);
        idle();
        check("b_in_flush", 32'(b_st), 32'd2);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
        idle();
        check("b_rst_mid_flush", {b_st, b_fc}, 32'd0);

        // Saturation at 15 on the 4-bit counter.
        for (int i = 0; i < 20; i++) hz_cyc();
        idle();
        check("b_sat", 32'(b_sc), 32'd15);
        check("a_no_sat", 32'(a_sc), 32'd20);

        // Randomized traffic, small register space to hit hazards often.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 60) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom),
                 ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
